// File: rtl/dram_slave_model_if.sv
// Cache-line request/response channel between the L1 master and the DRAM stand-in.
// The master drives requests and rsp_rdy; the slave drives req_rdy and responses.
interface dram_slave_model_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
);
  logic              req_en;
  logic              req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_rdy;
  logic              rsp_en;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_rdy;

  modport master (
    output req_en, req_cmd, req_addr, req_data, rsp_rdy,
    input  req_rdy, rsp_en, rsp_data
  );

  modport slave (
    input  req_en, req_cmd, req_addr, req_data, rsp_rdy,
    output req_rdy, rsp_en, rsp_data
  );
endinterface

// File: rtl/dram_slave_model.sv
// DRAM stand-in: in-order request queue serviced against a BRAM line store,
// with programmable read latency and a held read response.
//
//   state | meaning
//   IDLE  | pop the queue head; writes commit here, reads start the BRAM read
//   WAIT  | read latency countdown in cnt
//   RESP  | rsp_en held with stable data until rsp_rdy
module dram_slave_model #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 128,
  parameter int IDX_W       = 10,
  parameter int RD_LATENCY  = 4,
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic        sys_clk,
  input  logic        rst,
  dram_slave_model_if.slave bus,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  localparam int QDEPTH = 1 << QDEPTH_LOG2;
  localparam int CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [QDEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic                   full, empty, push, pop;
  logic                   rsp_en_q;
  logic [DATA_W-1:0]      rsp_data_q;
  logic [DATA_W-1:0]      rd_line;

  logic                   q_cmd  [QDEPTH];
  logic [IDX_W-1:0]       q_idx  [QDEPTH];
  logic [DATA_W-1:0]      q_data [QDEPTH];
  logic [DATA_W-1:0]      mem    [2**IDX_W];

  logic                   head_cmd;
  logic [IDX_W-1:0]       head_idx;
  logic [DATA_W-1:0]      head_data;

  // Only the line index selects storage; byte offset and high address bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:IDX_W+4], bus.req_addr[3:0]};

  assign full  = (wr_ptr[QDEPTH_LOG2] != rd_ptr[QDEPTH_LOG2]) &&
                 (wr_ptr[QDEPTH_LOG2-1:0] == rd_ptr[QDEPTH_LOG2-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign bus.req_rdy  = !full && !rst;
  assign bus.rsp_en   = rsp_en_q;
  assign bus.rsp_data = rsp_data_q;

  assign push = bus.req_en && bus.req_rdy;
  assign pop  = !rst && (state == ST_IDLE) && !empty;

  assign head_cmd  = q_cmd[rd_ptr[QDEPTH_LOG2-1:0]];
  assign head_idx  = q_idx[rd_ptr[QDEPTH_LOG2-1:0]];
  assign head_data = q_data[rd_ptr[QDEPTH_LOG2-1:0]];

  always_ff @(posedge sys_clk) begin
    if (push) begin
      q_cmd[wr_ptr[QDEPTH_LOG2-1:0]]  <= bus.req_cmd;
      q_idx[wr_ptr[QDEPTH_LOG2-1:0]]  <= bus.req_addr[IDX_W+3:4];
      q_data[wr_ptr[QDEPTH_LOG2-1:0]] <= bus.req_data;
    end
  end

  // Store has no reset; pop is already masked by rst so nothing commits during reset.
  always_ff @(posedge sys_clk) begin
    if (pop && !head_cmd) mem[head_idx] <= head_data;
    if (pop && head_cmd)  rd_line       <= mem[head_idx];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= ST_IDLE;
      cnt        <= '0;
      rsp_en_q   <= 1'b0;
      rsp_data_q <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (head_cmd) begin
              cnt   <= CNT_LOAD;
              state <= ST_WAIT;
            end else if (wr_count != 32'hFFFF_FFFF) begin
              wr_count <= wr_count + 32'd1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rsp_data_q <= rd_line;
            rsp_en_q   <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_rdy) begin
            rsp_en_q <= 1'b0;
            if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_slave_model.sv
// Directed bench for dram_slave_model: reset, latency, aliasing, ordering,
// backpressure, queue-full and reset-during-read behaviour.
module tb_dram_slave_model;
  logic        sys_clk = 1'b0;
  logic        rst;
  logic [31:0] rd_count, wr_count;

  dram_slave_model_if #(.ADDR_W(27), .DATA_W(128)) bus ();

  dram_slave_model dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .bus      (bus),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic         cmd;
    logic [26:0]  addr;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one request and hold it until the edge that accepts it.
  task automatic send(input logic cmd, input logic [26:0] addr, input logic [127:0] data);
    bit acc;
    acc = 1'b0;
    bus.req_en   = 1'b1;
    bus.req_cmd  = cmd;
    bus.req_addr = addr;
    bus.req_data = data;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = bus.req_rdy;
      step();
    end
    bus.req_en = 1'b0;
    if (!acc) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL send: request at %h not accepted within 64 cycles", addr);
    end
  endtask

  task automatic wait_rsp(input string name, input logic [127:0] exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus.rsp_en) begin
        seen = 1'b1;
        chk(name, bus.rsp_data, exp);
      end
      step();
    end
    if (!seen) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: no response within 64 cycles, expected %h", name, exp);
    end
  endtask

  localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DA = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
  localparam logic [127:0] DB = 128'hBBBB0000_BBBB0000_BBBB0000_BBBB0000;
  localparam logic [127:0] DC = 128'hC0FFEE00_DEADBEEF_CAFEF00D_12345678;
  localparam logic [127:0] DD = 128'hDDDDDDDD_00000001_DDDDDDDD_00000002;
  localparam logic [127:0] DE = 128'hEEEE1111_2222EEEE_3333EEEE_EEEE4444;
  localparam logic [127:0] JK = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  vec_t vecs [10];
  bit   bad;

  initial begin
    vecs[0] = '{1'b0, 27'h0000044, DA, '0};
    vecs[1] = '{1'b1, 27'h0000040, JK, DA};
    vecs[2] = '{1'b0, 27'h7FFFFF0, DB, '0};
    vecs[3] = '{1'b0, 27'h0003FF0, DC, '0};
    vecs[4] = '{1'b1, 27'h7FFFFF0, JK, DC};
    vecs[5] = '{1'b0, 27'h0000010, DD, '0};
    vecs[6] = '{1'b1, 27'h0000010, JK, DD};
    vecs[7] = '{1'b1, 27'h000004C, JK, DA};
    vecs[8] = '{1'b0, 27'h0000040, DE, '0};
    vecs[9] = '{1'b1, 27'h000004F, JK, DE};

    rst          = 1'b1;
    bus.req_en   = 1'b0;
    bus.req_cmd  = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.rsp_rdy  = 1'b1;

    // reset
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_req_rdy", bus.req_rdy, 0);
      chk("rst_rsp_en", bus.rsp_en, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
    end
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    rst = 1'b0;
    step();
    chk("post_rst_req_rdy", bus.req_rdy, 1);
    chk("post_rst_rsp_en", bus.rsp_en, 0);

    // write then read with exact latency
    send(1'b0, 27'h0000040, D0);
    repeat (3) step();
    send(1'b1, 27'h0000040, JK);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t2_lat_early", bus.rsp_en, 0);
    end
    step();
    chk("t2_rsp_en", bus.rsp_en, 1);
    chk("t2_rsp_data", bus.rsp_data, D0);
    step();
    chk("t2_rsp_one_cycle", bus.rsp_en, 0);
    chk("t2_rd_count", rd_count, 1);
    chk("t2_wr_count", wr_count, 1);

    // table: aliasing, in-order write/read
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].cmd, vecs[i].addr, vecs[i].data);
      if (vecs[i].cmd) wait_rsp($sformatf("vec%0d_rsp", i), vecs[i].exp);
    end
    repeat (2) step();
    chk("tbl_rd_count", rd_count, 6);
    chk("tbl_wr_count", wr_count, 6);

    // backpressure
    send(1'b0, 27'h0000100, DB);
    send(1'b0, 27'h0000110, DC);
    bus.rsp_rdy = 1'b0;
    send(1'b1, 27'h0000100, JK);
    send(1'b1, 27'h0000110, JK);
    wait_rsp("t4_first", DB);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_en", bus.rsp_en, 1);
      chk("t4_hold_data", bus.rsp_data, DB);
      step();
    end
    chk("t4_hold_rd_count", rd_count, 6);
    bus.rsp_rdy = 1'b1;
    step();
    chk("t4_release", bus.rsp_en, 0);
    chk("t4_rd_count", rd_count, 7);
    wait_rsp("t4_second", DC);

    // queue full
    for (int i = 0; i < 5; i++) send(1'b0, 27'h0000200 + 27'(i * 16), DA + 128'(i));
    repeat (3) step();
    bus.rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.req_en   = 1'b1;
      bus.req_cmd  = 1'b1;
      bus.req_addr = 27'h0000200 + 27'(i * 16);
      bus.req_data = JK;
      chk($sformatf("t5_accept%0d", i), bus.req_rdy, 1);
      step();
    end
    bus.req_en = 1'b0;
    chk("t5_full", bus.req_rdy, 0);
    repeat (6) step();
    chk("t5_still_full", bus.req_rdy, 0);
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < 5; i++) wait_rsp($sformatf("t5_rsp%0d", i), DA + 128'(i));
    chk("t5_rd_count", rd_count, 13);
    chk("t5_wr_count", wr_count, 13);

    // reset during WAIT
    repeat (2) step();
    send(1'b1, 27'h0000040, JK);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.rsp_en) bad = 1'b1;
      step();
    end
    chk("t6_no_rsp", bad, 0);
    chk("t6_rd_count", rd_count, 0);
    chk("t6_wr_count", wr_count, 0);
    send(1'b1, 27'h0000040, JK);
    wait_rsp("t6_new_read", DE);
    chk("t6_rd_count_after", rd_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
